// File: rtl/register_left_driver.sv
// Clocked initiator for the self-timed left-shift register: optional parallel load, then N
// single-bit shifts, each sequenced as a req/fin handshake with a synchronised fin.
module register_left_driver #(
  parameter int unsigned Width   = 32,
  parameter int unsigned ShiftW  = 6,
  parameter int unsigned MinWait = 4,
  parameter int unsigned Timeout = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmdValid,
  output logic              cmdReady,
  input  logic              cmdLoad,
  input  logic [Width-1:0]  cmdData,
  input  logic [ShiftW-1:0] cmdShift,
  output logic              saveReq,
  input  logic              saveFin,
  output logic              leftReq,
  input  logic              leftFin,
  output logic [Width-1:0]  regIn,
  input  logic [Width-1:0]  regOut,
  output logic              rspValid,
  input  logic              rspReady,
  output logic [Width-1:0]  rspData,
  output logic              rspErr,
  output logic              busy
);

  localparam int unsigned WaitW = $clog2(MinWait + 1);
  localparam int unsigned ToW   = $clog2(Timeout + 1);
  localparam logic [WaitW-1:0] WaitInit = WaitW'(MinWait);
  localparam logic [ToW-1:0]   ToMax    = ToW'(Timeout);

  typedef enum logic [2:0] {StIdle, StSaveReq, StLeftReq, StGap, StDone} state_e;

  state_e            state_q, state_d;
  logic [1:0]        save_sync_q, left_sync_q;
  logic              save_req_q, save_req_d;
  logic              left_req_q, left_req_d;
  logic [Width-1:0]  reg_in_q, reg_in_d;
  logic [Width-1:0]  rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rdy_q;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [WaitW-1:0]  hold_q, hold_d;
  logic [ToW-1:0]    to_q, to_d;
  logic [ShiftW-1:0] rem_q, rem_d;
  logic              gap_q, gap_d;
  logic              fin_sync;
  logic              in_req;
  logic              accept;

  assign cmdReady = rdy_q && (state_q == StIdle);
  assign busy     = (state_q != StIdle);
  assign rspValid = (state_q == StDone);
  assign saveReq  = save_req_q;
  assign leftReq  = left_req_q;
  assign regIn    = reg_in_q;
  assign rspData  = rsp_data_q;
  assign rspErr   = rsp_err_q;

  always_comb begin
    state_d    = state_q;
    reg_in_d   = reg_in_q;
    rsp_err_d  = rsp_err_q;
    rem_d      = rem_q;
    gap_d      = gap_q;
    wait_d     = wait_q;
    to_d       = to_q;
    accept     = cmdValid && cmdReady;
    in_req     = (state_q == StSaveReq) || (state_q == StLeftReq);
    fin_sync   = (state_q == StSaveReq) ? save_sync_q[1] : left_sync_q[1];
    // After reset the register may still be finishing; hold off new requests.
    hold_d     = (hold_q != '0) ? hold_q - 1'b1 : hold_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          reg_in_d  = cmdData;
          rem_d     = cmdShift;
          rsp_err_d = 1'b0;
          if (cmdLoad) begin
            state_d = StSaveReq;
          end else if (cmdShift != '0) begin
            state_d = StLeftReq;
          end else begin
            state_d = StDone;
          end
        end
      end
      StSaveReq, StLeftReq: begin
        if (hold_q == '0) begin
          if ((wait_q == '0) && fin_sync) begin
            state_d = StGap;
            if (state_q == StLeftReq) begin
              rem_d = rem_q - 1'b1;
            end
          end else if (to_q == ToMax) begin
            state_d   = StDone;
            rsp_err_d = 1'b1;
          end
        end
      end
      StGap: begin
        gap_d = 1'b1;
        if (gap_q) begin
          gap_d   = 1'b0;
          state_d = (rem_q != '0) ? StLeftReq : StDone;
        end
      end
      StDone: begin
        if (rspReady) begin
          state_d   = StIdle;
          rsp_err_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    // A request phase starts counting only once the post-reset hold-off has elapsed.
    if ((state_d != state_q) || (hold_q != '0)) begin
      wait_d = WaitInit;
      to_d   = '0;
    end else if (in_req) begin
      if (wait_q != '0) begin
        wait_d = wait_q - 1'b1;
      end
      to_d = to_q + 1'b1;
    end

    save_req_d = (state_d == StSaveReq) && (hold_d == '0);
    left_req_d = (state_d == StLeftReq) && (hold_d == '0);
    rsp_data_d = ((state_d == StDone) && (state_q != StDone)) ? regOut : rsp_data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      save_sync_q <= '0;
      left_sync_q <= '0;
      save_req_q  <= 1'b0;
      left_req_q  <= 1'b0;
      reg_in_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rdy_q       <= 1'b0;
      wait_q      <= '0;
      hold_q      <= WaitInit;
      to_q        <= '0;
      rem_q       <= '0;
      gap_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      save_sync_q <= {save_sync_q[0], saveFin};
      left_sync_q <= {left_sync_q[0], leftFin};
      save_req_q  <= save_req_d;
      left_req_q  <= left_req_d;
      reg_in_q    <= reg_in_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rdy_q       <= 1'b1;
      wait_q      <= wait_d;
      hold_q      <= hold_d;
      to_q        <= to_d;
      rem_q       <= rem_d;
      gap_q       <= gap_d;
    end
  end

endmodule

// File: tb/tb_register_left_driver.sv
// Scoreboard bench for register_left_driver with a 3-cycle self-timed register model.
module tb_register_left_driver;

  localparam int unsigned Width   = 32;
  localparam int unsigned ShiftW  = 6;
  localparam int unsigned MinWait = 4;
  localparam int unsigned Timeout = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmdValid, cmdReady, cmdLoad;
  logic [Width-1:0]  cmdData;
  logic [ShiftW-1:0] cmdShift;
  logic              saveReq, saveFin, leftReq, leftFin;
  logic [Width-1:0]  regIn, regOut;
  logic              rspValid, rspReady, rspErr, busy;
  logic [Width-1:0]  rspData;

  always #5 clk = ~clk;

  register_left_driver #(
    .Width  (Width),
    .ShiftW (ShiftW),
    .MinWait(MinWait),
    .Timeout(Timeout)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cmdValid(cmdValid),
    .cmdReady(cmdReady),
    .cmdLoad (cmdLoad),
    .cmdData (cmdData),
    .cmdShift(cmdShift),
    .saveReq (saveReq),
    .saveFin (saveFin),
    .leftReq (leftReq),
    .leftFin (leftFin),
    .regIn   (regIn),
    .regOut  (regOut),
    .rspValid(rspValid),
    .rspReady(rspReady),
    .rspData (rspData),
    .rspErr  (rspErr),
    .busy    (busy)
  );

  // Self-timed register: acts and raises fin 3 cycles after req rises, drops fin 3 after fall.
  logic [2:0]       sdly = '0;
  logic [2:0]       ldly = '0;
  logic [Width-1:0] reg_val = '0;
  logic             kill_left = 1'b0;
  int               cyc = 0;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    sdly <= {sdly[1:0], saveReq === 1'b1};
    ldly <= {ldly[1:0], (leftReq === 1'b1) && !kill_left};
    if (sdly[1] && !sdly[2]) reg_val <= regIn;
    if (ldly[1] && !ldly[2]) reg_val <= reg_val << 1;
  end
  assign saveFin = sdly[2];
  assign leftFin = ldly[2];
  assign regOut  = reg_val;

  typedef struct {
    logic [Width-1:0] data;
    logic             err;
    int               nsave;
    int               nleft;
  } exp_t;

  exp_t             sb_q[$];
  int               checks = 0;
  int               passes = 0;
  logic [Width-1:0] shadow = '0;
  int               rdy_delay = 0;
  int               save_pulses = 0, left_pulses = 0, viol = 0;
  int               low_run = 100, left_hi = 0, last_left_hi = 0;
  int               save_rise_cyc = 0, rel_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [Width-1:0] shl(input logic [Width-1:0] v, input int n);
    return (n >= int'(Width)) ? '0 : (v << n);
  endfunction

  // Monitor: drives rspReady, tracks request pulses and compares responses against the queue.
  initial begin
    int  vc;
    logic ps, pl;
    vc = 0; ps = 1'b0; pl = 1'b0;
    rspReady = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        save_pulses = 0; left_pulses = 0; viol = 0; low_run = 100; left_hi = 0;
        vc = 0; ps = 1'b0; pl = 1'b0; rspReady = 1'b0;
      end else begin
        if (saveReq && leftReq) viol++;
        if ((saveReq && !ps) || (leftReq && !pl)) begin
          if (low_run < 2) viol++;
        end
        if (saveReq && !ps) begin save_pulses++; save_rise_cyc = cyc; end
        if (leftReq && !pl) left_pulses++;
        low_run = (saveReq || leftReq) ? 0 : low_run + 1;
        if (leftReq) left_hi++;
        else if (left_hi > 0) begin last_left_hi = left_hi; left_hi = 0; end
        ps = saveReq; pl = leftReq;

        if (rspValid) begin
          vc++;
          rspReady = (vc > rdy_delay);
          if (sb_q.size() == 0) begin
            chk("unexpected_rsp", 64'd1, 64'd0);
          end else begin
            chk("rsp_data", rspData, sb_q[0].data);
            if (rspReady) begin
              chk("rsp_err", rspErr, sb_q[0].err);
              chk("save_pulses", save_pulses, sb_q[0].nsave);
              chk("left_pulses", left_pulses, sb_q[0].nleft);
              chk("req_overlap_gap", viol, 0);
              void'(sb_q.pop_front());
              save_pulses = 0; left_pulses = 0; viol = 0; vc = 0;
            end
          end
        end else begin
          rspReady = 1'b0;
          vc = 0;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input bit load, input logic [Width-1:0] data, input int sh, input bit drop);
    int   n;
    exp_t e;
    logic [Width-1:0] base;
    cmdValid = 1'b1; cmdLoad = load; cmdData = data; cmdShift = ShiftW'(sh);
    n = 0;
    while (!cmdReady && n < 3000) begin @(negedge clk); n++; end
    if (!cmdReady) begin
      chk("accept_timeout", 64'd0, 64'd1);
      cmdValid = 1'b0;
    end else begin
      chk("no_outstanding_at_accept", sb_q.size(), 0);
      base    = load ? data : shadow;
      e.nsave = load ? 1 : 0;
      if (kill_left && sh != 0) begin
        e.data = base; e.err = 1'b1; e.nleft = 1;
      end else begin
        e.data = shl(base, sh); e.err = 1'b0; e.nleft = sh;
      end
      shadow = e.data;
      sb_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      if (drop) cmdValid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || !cmdReady) && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) chk("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; cmdValid = 1'b0; cmdLoad = 1'b0; cmdData = '0; cmdShift = '0;
    repeat (5) @(negedge clk);
    chk("rst_saveReq", saveReq, 0);
    chk("rst_leftReq", leftReq, 0);
    chk("rst_cmdReady", cmdReady, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rspValid", rspValid, 0);
    chk("rst_regIn", regIn, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", cmdReady, 1);

    // Load + 4 shifts
    send(1'b1, 32'h0000_00A5, 4, 1'b1);
    wait_done();
    chk("a5_shadow", shadow, 32'h0000_0A50);

    // Shift-only, zero count: response one cycle after acceptance
    send(1'b0, 32'h0, 0, 1'b1);
    chk("zero_shift_latency", rspValid, 1);
    chk("zero_shift_no_req", {saveReq, leftReq}, 0);
    wait_done();

    // Register never finishes a shift: timeout, then a normal command
    kill_left = 1'b1;
    send(1'b1, 32'hDEAD_BEEF, 3, 1'b1);
    wait_done();
    chk("timeout_req_len", last_left_hi, Timeout + 1);
    kill_left = 1'b0;
    send(1'b0, 32'h0, 1, 1'b1);
    wait_done();

    // cmdValid held through an op while the response is stalled for 5 cycles
    rdy_delay = 5;
    send(1'b1, 32'h1357_9BDF, 2, 1'b0);
    send(1'b1, 32'h0F0F_1234, 1, 1'b1);
    wait_done();
    rdy_delay = 0;

    // Reset during the 2nd of 3 shifts
    send(1'b1, 32'h1234_5678, 3, 1'b1);
    begin
      int n;
      n = 0;
      while (!(left_pulses == 2 && leftReq) && n < 500) begin @(negedge clk); n++; end
      chk("reached_2nd_shift", n < 500, 1);
    end
    rst_n = 1'b0;
    @(negedge clk);
    sb_q.delete();
    chk("midrst_saveReq", saveReq, 0);
    chk("midrst_leftReq", leftReq, 0);
    chk("midrst_rspValid", rspValid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_rspData", rspData, 0);
    chk("midrst_rspErr", rspErr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rel_cyc = cyc;
    @(negedge clk);
    chk("ready_after_midrst", cmdReady, 1);
    send(1'b1, 32'h0000_0F00, 1, 1'b1);
    wait_done();
    chk("reset_holdoff", (save_rise_cyc - rel_cyc) >= int'(MinWait), 1);

    // All-ones loaded, shifted past the width
    send(1'b1, 32'hFFFF_FFFF, 33, 1'b1);
    wait_done();

    for (int i = 0; i < 12; i++) begin
      rdy_delay = $urandom_range(0, 3);
      send(1'($urandom_range(0, 1)), $urandom, ((i % 4) == 3) ? 63 : $urandom_range(0, 40),
           1'b1);
      wait_done();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
